chunked_adder_sequencer: RTL and testbench
==========================================

// Module: chunked_adder_sequencer
// PURPOSE
//  Computes a WIDTH-bit add over several cycles by time-sharing one CHUNK-bit ripple
//  adder (full_adder chain), one chunk per clock, LSB chunk first, with a registered
//  inter-chunk carry. Trades latency for area in wide-operand datapaths. Valid/ready
//  handshake on both the operand side and the result side.
// PARAMETERS
//  WIDTH   64  operand width; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  CHUNK   16  width of the shared ripple adder; NCHUNK = WIDTH/CHUNK (>=1)
// PORTS
//  i_clk     in   1        clock, rising edge
//  i_rst     in   1        synchronous reset, active-high
//  i_valid   in   1        operands valid
//  o_ready   out  1        block can accept operands
//  i_add1    in   WIDTH    operand A
//  i_add2    in   WIDTH    operand B
//  o_valid   out  1        result valid
//  i_ready   in   1        downstream accepts result
//  o_result  out  WIDTH+1  sum; bit WIDTH = final carry out
// BEHAVIOUR
//  - Reset (sync): state IDLE, o_ready=1, o_valid=0, o_result=0, count=0, carry=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE. o_ready=1 only in IDLE. o_valid=1 only in DONE.
//  - IDLE: on i_valid&o_ready edge: latch i_add1/i_add2 into operand regs, carry=0,
//    count=0, -> RUN. i_valid without the handshake has no effect.
//  - RUN: each edge adds operand chunk[count] + carry via the CHUNK-bit adder, writes
//    sum into o_result[count*CHUNK +: CHUNK], carry <= adder carry-out, count++.
//    On the edge processing count==NCHUNK-1: o_result[WIDTH] <= carry-out, -> DONE.
//  - Latency: accept at edge E0 -> o_valid high from edge E0+NCHUNK.
//  - DONE: o_result held stable while o_valid=1 and i_ready=0 (unbounded backpressure).
//    On o_valid&i_ready edge -> IDLE; o_ready rises that edge. No accept in DONE;
//    min spacing between accepts = NCHUNK+2 edges.
//  - Operand inputs are ignored outside the accept edge (changes during RUN: no effect).
//  - Arithmetic is modulo 2^(WIDTH+1); no overflow flag beyond bit WIDTH.
//  - Reset mid-RUN/DONE: operation discarded, outputs return to reset values at the
//    reset edge; no partial result ever presented with o_valid=1.
//  - NCHUNK==1 is legal: single RUN cycle.
// CONFIGURATION
//  SUBTRACT_EN defined: extra port i_sub (in,1), latched at accept. i_sub=1 computes
//    A-B: operand B inverted when latched, initial carry=1; o_result[WIDTH] = carry
//    out = 1 when A>=B (no borrow). i_sub=0 identical to plain add.
//  SUBTRACT_EN undefined: no i_sub port; always add, initial carry=0.
// TESTING (WIDTH=64, CHUNK=16)
//  1. Reset, accept 1+1 -> o_valid rises exactly 4 edges after accept, o_result=65'd2.
//  2. 64'hFFFF_FFFF_FFFF_FFFF + 1 -> o_result=65'h1_0000_0000_0000_0000 (carry
//     crosses all 3 chunk boundaries).
//  3. Result with i_ready=0 for 5 cycles, i_valid=1 with new operands throughout ->
//     o_valid/o_result stable, o_ready=0, new operands not taken until after handshake.
//  4. Assert i_rst during RUN at count=2 -> next cycle o_valid=0, o_ready=1; then
//     5+7 -> o_result=12 with no residue of aborted op.
//  5. i_valid=1, i_ready=1 continuously, 10 random ops -> accepts every 6 edges, all
//     results match reference model, in order.
//  6. SUBTRACT_EN: 10-3 -> o_result[63:0]=7, bit64=1; 3-10 ->
//     o_result[63:0]=64'hFFFF_FFFF_FFFF_FFF9, bit64=0.

Source files
------------

// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit ripple adder, LSB chunk first.
// Optional macro SUBTRACT_EN adds an i_sub port selecting A-B instead of A+B.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunked_adder_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
`ifdef SUBTRACT_EN
    input  logic             i_sub,
`endif
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_adder_sequencer: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             step;
    logic             sub_mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic [CHUNK:0]   ripple;

`ifdef SUBTRACT_EN
    assign sub_mode = i_sub;
`else
    assign sub_mode = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The shared adder sees whichever chunk the counter currently points at.
    assign a_chunk   = op_a[int'(count) * CHUNK +: CHUNK];
    assign b_chunk   = op_b[int'(count) * CHUNK +: CHUNK];
    assign ripple[0] = carry;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (a_chunk[gi]),
                .b    (b_chunk[gi]),
                .cin  (ripple[gi]),
                .sum  (sum_chunk[gi]),
                .cout (ripple[gi+1])
            );
        end
    endgenerate

    // Subtraction is A + ~B + 1: invert B once at capture and seed the carry with 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            o_result <= '0;
        end else if (accept) begin
            op_a  <= i_add1;
            op_b  <= sub_mode ? ~i_add2 : i_add2;
            carry <= sub_mode;
            count <= '0;
        end else if (step) begin
            o_result[int'(count) * CHUNK +: CHUNK] <= sum_chunk;
            carry <= ripple[CHUNK];
            count <= count + CNT_W'(1);
            if (count == LAST) begin
                o_result[WIDTH] <= ripple[CHUNK];
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Self-checking bench for chunked_adder_sequencer (WIDTH=64, CHUNK=16) against an arithmetic model.
// Define SUBTRACT_EN for both bench and RTL to exercise the subtract option.

module tb_chunked_adder_sequencer;

    localparam int WIDTH = 64;
    localparam int CHUNK = 16;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] add1;
    logic [WIDTH-1:0] add2;
    logic             sub;
    logic             out_valid;
    logic             down_ready;
    logic [WIDTH:0]   result;

    int checks = 0;
    int fails  = 0;

    chunked_adder_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_add1   (add1),
        .i_add2   (add2),
`ifdef SUBTRACT_EN
        .i_sub    (sub),
`endif
        .o_valid  (out_valid),
        .i_ready  (down_ready),
        .o_result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
        logic [WIDTH:0] ea;
        logic [WIDTH:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        if (s) return ea + {1'b0, ~b} + 65'd1;
        return ea + eb;
    endfunction

    function automatic logic [WIDTH-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction through accept, wait and handshake; comparisons stay with callers.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          output int lat, output logic [WIDTH:0] res, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (!out_ready && n < 20) begin
            step();
            n++;
        end
        if (!out_ready) ok = 1'b0;
        add1     = a;
        add2     = b;
        sub      = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        add1     = rand64();
        add2     = rand64();
        sub      = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        res        = result;
        down_ready = 1'b1;
        step();
        down_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        down_ready = 1'b0;
        add1       = '0;
        add2       = '0;
        sub        = 1'b0;
        step();
        step();
        checks++;
        if (out_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", out_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== '0) begin
            fails++;
            $display("[TB] FAIL reset_result: got %h expected 0", result);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        logic [WIDTH:0] res;
        bit ok;
        run_op(64'd1, 64'd1, 1'b0, lat, res, ok);
        checks++;
        if (ok !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_timeout: handshake bound expired");
        end
        checks++;
        if (lat !== NCHUNK) begin
            fails++;
            $display("[TB] FAIL basic_latency: got %0d edges expected %0d", lat, NCHUNK);
        end
        checks++;
        if (res !== 65'd2) begin
            fails++;
            $display("[TB] FAIL basic_result: got %h expected %h", res, 65'd2);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        logic [WIDTH:0] res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit ok;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== 65'h1_0000_0000_0000_0000) begin
            fails++;
            $display("[TB] FAIL carry_all_chunks: got %h expected %h ok=%0d", res,
                     65'h1_0000_0000_0000_0000, ok);
        end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== 65'h1_FFFF_FFFF_FFFF_FFFE) begin
            fails++;
            $display("[TB] FAIL carry_max_max: got %h expected %h", res, 65'h1_FFFF_FFFF_FFFF_FFFE);
        end
        run_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== 65'h0_0001_0000_0001_0000) begin
            fails++;
            $display("[TB] FAIL carry_alternate: got %h expected %h", res, 65'h0_0001_0000_0001_0000);
        end
        for (int i = 0; i < 4; i++) begin
            a = rand64();
            b = rand64();
            run_op(a, b, 1'b0, lat, res, ok);
            checks++;
            if (!ok || res !== model(a, b, 1'b0)) begin
                fails++;
                $display("[TB] FAIL carry_random%0d: got %h expected %h", i, res, model(a, b, 1'b0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] b0;
        logic [WIDTH-1:0] a2;
        logic [WIDTH-1:0] b2;
        int n;
        a0 = rand64();
        b0 = rand64();
        add1     = a0;
        add2     = b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            add1     = rand64();
            add2     = rand64();
            checks++;
            if (out_valid !== 1'b1 || out_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold_flags%0d: got valid=%b ready=%b expected valid=1 ready=0",
                         k, out_valid, out_ready);
            end
            checks++;
            if (result !== model(a0, b0, 1'b0)) begin
                fails++;
                $display("[TB] FAIL bp_hold_result%0d: got %h expected %h", k, result, model(a0, b0, 1'b0));
            end
            step();
        end
        a2         = rand64();
        b2         = rand64();
        add1       = a2;
        add2       = b2;
        down_ready = 1'b1;
        step();
        down_ready = 1'b0;
        checks++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0",
                     out_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_accept_after: got ready=%b expected 0", out_ready);
        end
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== NCHUNK || result !== model(a2, b2, 1'b0)) begin
            fails++;
            $display("[TB] FAIL bp_next_op: got %h after %0d edges expected %h after %0d",
                     result, n, model(a2, b2, 1'b0), NCHUNK);
        end
        down_ready = 1'b1;
        step();
        down_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int n;
        logic [WIDTH:0] res;
        bit ok;
        add1     = rand64();
        add2     = rand64();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || result !== '0) begin
            fails++;
            $display("[TB] FAIL rst_run: got valid=%b ready=%b result=%h expected 0/1/0",
                     out_valid, out_ready, result);
        end
        rst = 1'b0;
        run_op(64'd5, 64'd7, 1'b0, lat, res, ok);
        checks++;
        if (!ok || lat !== NCHUNK || res !== 65'd12) begin
            fails++;
            $display("[TB] FAIL rst_run_next: got %h lat %0d expected %h lat %0d", res, lat, 65'd12, NCHUNK);
        end
        add1     = rand64();
        add2     = rand64();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ready !== 1'b1 || result !== '0) begin
            fails++;
            $display("[TB] FAIL rst_done: got valid=%b ready=%b result=%h expected 0/1/0",
                     out_valid, out_ready, result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] exp_q[$];
        int acc_q[$];
        logic [WIDTH:0] exp_r;
        int acc_edge;
        int last_acc;
        int accepts;
        int results;
        int cyc;
        bit will_accept;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        accepts    = 0;
        results    = 0;
        cyc        = 0;
        last_acc   = 0;
        in_valid   = 1'b1;
        down_ready = 1'b1;
        while (results < 10 && cyc < 200) begin
            a    = rand64();
            b    = rand64();
            add1 = a;
            add2 = b;
            will_accept = out_ready;
            step();
            cyc++;
            if (will_accept) begin
                exp_q.push_back(model(a, b, 1'b0));
                acc_q.push_back(cyc);
                if (accepts > 0) begin
                    checks++;
                    if (cyc - last_acc !== NCHUNK + 2) begin
                        fails++;
                        $display("[TB] FAIL b2b_spacing: got %0d edges expected %0d", cyc - last_acc, NCHUNK + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL b2b_spurious: got result %h expected no result", result);
                end else begin
                    exp_r    = exp_q.pop_front();
                    acc_edge = acc_q.pop_front();
                    checks++;
                    if (result !== exp_r || cyc - acc_edge !== NCHUNK) begin
                        fails++;
                        $display("[TB] FAIL b2b_result%0d: got %h after %0d edges expected %h after %0d",
                                 results, result, cyc - acc_edge, exp_r, NCHUNK);
                    end
                end
                results++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (results !== 10) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d results expected 10", results);
        end
        step();
        down_ready = 1'b0;
        step();
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        int lat;
        logic [WIDTH:0] res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit ok;
        run_op(64'd10, 64'd3, 1'b1, lat, res, ok);
        checks++;
        if (!ok || res !== 65'h1_0000_0000_0000_0007) begin
            fails++;
            $display("[TB] FAIL sub_10_3: got %h expected %h", res, 65'h1_0000_0000_0000_0007);
        end
        run_op(64'd3, 64'd10, 1'b1, lat, res, ok);
        checks++;
        if (!ok || res !== 65'h0_FFFF_FFFF_FFFF_FFF9) begin
            fails++;
            $display("[TB] FAIL sub_3_10: got %h expected %h", res, 65'h0_FFFF_FFFF_FFFF_FFF9);
        end
        for (int i = 0; i < 4; i++) begin
            a = rand64();
            b = rand64();
            run_op(a, b, i[0], lat, res, ok);
            checks++;
            if (!ok || res !== model(a, b, i[0])) begin
                fails++;
                $display("[TB] FAIL sub_random%0d: got %h expected %h", i, res, model(a, b, i[0]));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
